sobel_dma_ctrl: RTL and testbench
=================================

# sobel_dma_ctrl

Request sequencer for the Sobel AFU. It turns one programmed job (source buffer, destination buffer, byte size, DSM address) into cache-line read requests on CCI-P channel 0 and write requests on channel 1. Read requests are paced by an outstanding-request limit and the channel almost-full signals. Writes are paced by the filter engine's output lines. When the job completes, the block issues a completion write to the DSM line. It sits between the MMIO/CSR decode logic and the CCI-P Tx muxing. Data payloads do not pass through it; it produces only valid/address/select signals.

## Interface
- MAX_OUTSTANDING, 64: max read requests issued but not yet answered (power of 2, 2..512)
- LINE_W, 42: cache-line address width
- clk  in  1  AFU clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- ctl_start  in  1  one-cycle pulse: latch job registers, begin job (ignored unless IDLE)
- ctl_stop  in  1  one-cycle pulse: abort current job
- src_addr  in  64  source byte address, 64B-aligned (bits [5:0] ignored)
- dst_addr  in  64  destination byte address, 64B-aligned
- dsm_addr  in  64  DSM byte address, 64B-aligned
- size  in  32  job size in bytes
- c0_almfull  in  1  CCI-P c0 Tx almost full
- c1_almfull  in  1  CCI-P c1 Tx almost full
- rd_req_valid  out  1  issue read this cycle
- rd_req_addr  out  LINE_W  read line address
- rd_rsp_valid  in  1  one read response accepted by engine
- out_line_valid  in  1  engine has an output line
- out_line_ready  out  1  engine line consumed this cycle (equals wr_req_valid & ~wr_req_is_dsm)
- wr_req_valid  out  1  issue write this cycle
- wr_req_addr  out  LINE_W  write line address
- wr_req_is_dsm  out  1  write carries the completion record, not engine data
- wr_rsp_valid  in  1  one write response
- busy  out  1  job in progress (not IDLE)
- done  out  1  sticky; set when DSM write response arrives, cleared by next ctl_start
- aborted  out  1  sticky; set when abort drain completes, cleared by next ctl_start
- perf_cycles  out  32  job cycle count (see Configuration)

## Operation
- At ctl_start, `lines` = (size + 63) >> 6, computed at 27 bits. Line addresses are addr[LINE_W+5:6] + index, and wrap modulo 2^LINE_W.
- Counters: rd_issued, rd_done, wr_issued, wr_done are 27 bits each; outstanding is $clog2(MAX_OUTSTANDING)+1 bits.
- States:
  - IDLE: wait for ctl_start. On ctl_start, latch inputs and go to RUN. If lines==0, go directly to DSM.
  - RUN: reads and writes proceed concurrently.
    - A read issues when rd_issued<lines, outstanding<MAX_OUTSTANDING and !c0_almfull.
    - A data write issues when out_line_valid, wr_issued<lines and !c1_almfull.
    - When wr_done==lines, go to DSM.
  - DSM: assert wr_req_valid with wr_req_is_dsm=1 and addr=dsm_addr[LINE_W+5:6] on the first cycle with !c1_almfull, exactly once. Then go to WAIT_DSM.
  - WAIT_DSM: on wr_rsp_valid, set done and go to IDLE.
  - DRAIN: entered on ctl_stop from RUN, DSM or WAIT_DSM. No new requests are issued. Wait until rd_issued==rd_done and wr_issued==wr_done (counting the DSM write if it was issued). Then set aborted and go to IDLE.
- ctl_stop in IDLE is ignored. ctl_start outside IDLE is ignored.
- If ctl_stop and a request condition occur in the same cycle, the stop wins and no request is issued.
- If a read issue and an rd_rsp_valid occur in the same cycle, outstanding is unchanged.
- Responses arriving in IDLE, or beyond the issued counts, are ignored; the counters saturate.

## Timing
- All outputs are registered. Reset values: every output is 0, all counters are 0, and state is IDLE.
- ctl_start at cycle N gives busy=1 at N+1. The first rd_req_valid can occur at N+1.
- Issue rate is at most one read and one write per cycle.
- The almfull inputs are sampled in the cycle the request is decided. A request is never issued in a cycle where the corresponding almfull is 1.
- Final wr_rsp_valid at cycle M gives the DSM write at M+1 if c1_almfull=0.
- DSM write response at cycle K gives done=1 and busy=0 at K+1.
- reset_n low mid-job returns the block to IDLE the next cycle. Responses still in flight after reset are ignored.

## Configuration
- SOBEL_DMA_PERF_EN defined: a 32-bit counter clears at ctl_start, increments every busy cycle, and freezes at done or aborted. perf_cycles shows the counter.
- SOBEL_DMA_PERF_EN undefined: the counter is not built and perf_cycles is tied to 0.

## Test plan
- size=256, src=0x1000, dst=0x2000, dsm=0x3000, responses returned after 1 cycle:
  - reads go to lines 0x40..0x43 and writes to lines 0x80..0x83.
  - The DSM write goes to 0xC0, and done=1.
  - With PERF_EN, perf_cycles equals the number of busy cycles.
- size=100: exactly 2 reads and 2 writes. size=0: no data requests; a single DSM write, then done.
- MAX_OUTSTANDING=4, size=1024, read responses withheld: exactly 4 reads issue and then stall. Each rd_rsp_valid releases exactly one further read.
- c0_almfull held high for 10 cycles mid-job: no rd_req_valid during those cycles, and reads resume the cycle after it drops. Same check for c1_almfull on writes and on the DSM write.
- ctl_stop after 3 of 8 reads issue: no further requests. After the 3 outstanding responses arrive, aborted=1, done=0 and no DSM write occurs. A following ctl_start clears aborted and runs a full job.
- reset_n pulsed low mid-RUN: the next cycle shows busy=0 and all outputs 0. Late rd_rsp_valid and wr_rsp_valid pulses cause no requests.

Source files
------------

// File: rtl/sobel_dma_ctrl.sv
// Sobel AFU request sequencer: turns one programmed job into CCI-P c0 read and
// c1 write requests plus a DSM completion write. SOBEL_DMA_PERF_EN builds the job cycle counter.
module sobel_dma_ctrl #(
  parameter int MAX_OUTSTANDING = 64,
  parameter int LINE_W          = 42
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ctl_start,
  input  logic              ctl_stop,
  input  logic [63:0]       src_addr,
  input  logic [63:0]       dst_addr,
  input  logic [63:0]       dsm_addr,
  input  logic [31:0]       size,
  input  logic              c0_almfull,
  input  logic              c1_almfull,
  output logic              rd_req_valid,
  output logic [LINE_W-1:0] rd_req_addr,
  input  logic              rd_rsp_valid,
  input  logic              out_line_valid,
  output logic              out_line_ready,
  output logic              wr_req_valid,
  output logic [LINE_W-1:0] wr_req_addr,
  output logic              wr_req_is_dsm,
  input  logic              wr_rsp_valid,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [31:0]       perf_cycles
);
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DSM, S_WAIT_DSM, S_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [26:0]         lines_q;
  logic [LINE_W-1:0]   src_q, dst_q, dsm_q;
  logic [26:0]         rd_issued_q, rd_done_q, wr_issued_q, wr_done_q;
  logic [OW-1:0]       outst_q;
  logic                dsm_pend_q;
  logic                rd_req_valid_q, wr_req_valid_q, wr_is_dsm_q;
  logic [LINE_W-1:0]   rd_req_addr_q, wr_req_addr_q;
  logic                busy_q, done_q, aborted_q;

  logic                start, rd_go, wr_go, dsm_go, set_done, set_abort;
  logic                rd_rsp_acc, wr_rsp_acc, dsm_rsp;
  logic [32:0]         size_rnd;
  logic [26:0]         lines_in, wr_done_nx;
  logic [LINE_W-1:0]   rd_addr_d, wr_addr_d;
  logic                unused_bits;

  assign size_rnd   = {1'b0, size} + 33'd63;
  assign lines_in   = size_rnd[32:6];

  // Responses outside a job or beyond what was issued are dropped, so counters saturate.
  assign rd_rsp_acc = rd_rsp_valid && (state_q != S_IDLE) && (rd_done_q < rd_issued_q);
  assign wr_rsp_acc = wr_rsp_valid && (state_q != S_IDLE) && (wr_done_q < wr_issued_q);
  assign dsm_rsp    = wr_rsp_valid && (state_q != S_IDLE) && !wr_rsp_acc && dsm_pend_q;
  assign wr_done_nx = wr_done_q + 27'(wr_rsp_acc);

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    rd_go     = 1'b0;
    wr_go     = 1'b0;
    dsm_go    = 1'b0;
    set_done  = 1'b0;
    set_abort = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ctl_start) begin
          start = 1'b1;
          if (lines_in == '0) begin
            dsm_go  = !c1_almfull;
            state_d = c1_almfull ? S_DSM : S_WAIT_DSM;
          end else begin
            rd_go   = !c0_almfull;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (ctl_stop) begin
          state_d = S_DRAIN;
        end else begin
          rd_go = (rd_issued_q < lines_q) && (outst_q < OW'(MAX_OUTSTANDING)) && !c0_almfull;
          wr_go = out_line_valid && (wr_issued_q < lines_q) && !c1_almfull;
          // Decide the DSM write in the same cycle as the last data response.
          if (wr_done_nx == lines_q) begin
            dsm_go  = !c1_almfull;
            state_d = c1_almfull ? S_DSM : S_WAIT_DSM;
          end
        end
      end
      S_DSM: begin
        if (ctl_stop) state_d = S_DRAIN;
        else if (!c1_almfull) begin
          dsm_go  = 1'b1;
          state_d = S_WAIT_DSM;
        end
      end
      S_WAIT_DSM: begin
        if (ctl_stop) state_d = S_DRAIN;
        else if (dsm_rsp) begin
          set_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_DRAIN: begin
        if ((rd_issued_q == rd_done_q) && (wr_issued_q == wr_done_q) && !dsm_pend_q) begin
          set_abort = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_addr_d = start ? src_addr[LINE_W+5:6] : src_q + LINE_W'(rd_issued_q);
  assign wr_addr_d = dsm_go ? (start ? dsm_addr[LINE_W+5:6] : dsm_q)
                            : dst_q + LINE_W'(wr_issued_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      lines_q        <= '0;
      src_q          <= '0;
      dst_q          <= '0;
      dsm_q          <= '0;
      rd_issued_q    <= '0;
      rd_done_q      <= '0;
      wr_issued_q    <= '0;
      wr_done_q      <= '0;
      outst_q        <= '0;
      dsm_pend_q     <= 1'b0;
      rd_req_valid_q <= 1'b0;
      rd_req_addr_q  <= '0;
      wr_req_valid_q <= 1'b0;
      wr_req_addr_q  <= '0;
      wr_is_dsm_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      aborted_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        lines_q <= lines_in;
        src_q   <= src_addr[LINE_W+5:6];
        dst_q   <= dst_addr[LINE_W+5:6];
        dsm_q   <= dsm_addr[LINE_W+5:6];
      end
      rd_issued_q <= (start ? '0 : rd_issued_q) + 27'(rd_go);
      rd_done_q   <= (start ? '0 : rd_done_q) + 27'(rd_rsp_acc);
      wr_issued_q <= (start ? '0 : wr_issued_q) + 27'(wr_go);
      wr_done_q   <= start ? '0 : wr_done_nx;
      outst_q     <= (start ? '0 : outst_q) + OW'(rd_go) - OW'(rd_rsp_acc);
      if (dsm_go)                dsm_pend_q <= 1'b1;
      else if (start || dsm_rsp) dsm_pend_q <= 1'b0;
      rd_req_valid_q <= rd_go;
      if (rd_go) rd_req_addr_q <= rd_addr_d;
      wr_req_valid_q <= wr_go || dsm_go;
      wr_is_dsm_q    <= dsm_go;
      if (wr_go || dsm_go) wr_req_addr_q <= wr_addr_d;
      busy_q    <= (state_d != S_IDLE);
      done_q    <= !start && (done_q || set_done);
      aborted_q <= !start && (aborted_q || set_abort);
    end
  end

`ifdef SOBEL_DMA_PERF_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk) begin
    if (!reset_n)                           perf_q <= '0;
    else if (start)                         perf_q <= '0;
    else if (busy_q && !done_q && !aborted_q) perf_q <= perf_q + 32'd1;
  end
  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

  assign rd_req_valid   = rd_req_valid_q;
  assign rd_req_addr    = rd_req_addr_q;
  assign wr_req_valid   = wr_req_valid_q;
  assign wr_req_addr    = wr_req_addr_q;
  assign wr_req_is_dsm  = wr_is_dsm_q;
  assign out_line_ready = wr_req_valid_q && !wr_is_dsm_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign aborted        = aborted_q;

  assign unused_bits = ^{src_addr, dst_addr, dsm_addr};

endmodule

// File: tb/tb_sobel_dma_ctrl.sv
// Bench for sobel_dma_ctrl: directed scenarios plus randomized jobs checked
// against a job-level model (expected line lists, ordering, pacing rules).
module tb_sobel_dma_ctrl;
  localparam int MAXO = 4;
  localparam logic [63:0] LMASK = 64'h3FF_FFFF_FFFF;

  logic        clk, reset_n, ctl_start, ctl_stop;
  logic [63:0] src_addr, dst_addr, dsm_addr;
  logic [31:0] size;
  logic        c0_almfull, c1_almfull;
  logic        rd_req_valid, rd_rsp_valid, out_line_valid, out_line_ready;
  logic [41:0] rd_req_addr, wr_req_addr;
  logic        wr_req_valid, wr_req_is_dsm, wr_rsp_valid;
  logic        busy, done, aborted;
  logic [31:0] perf_cycles;

  sobel_dma_ctrl #(.MAX_OUTSTANDING(MAXO), .LINE_W(42)) dut (
    .clk(clk), .reset_n(reset_n), .ctl_start(ctl_start), .ctl_stop(ctl_stop),
    .src_addr(src_addr), .dst_addr(dst_addr), .dsm_addr(dsm_addr), .size(size),
    .c0_almfull(c0_almfull), .c1_almfull(c1_almfull),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_rsp_valid(rd_rsp_valid),
    .out_line_valid(out_line_valid), .out_line_ready(out_line_ready),
    .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_is_dsm(wr_req_is_dsm),
    .wr_rsp_valid(wr_rsp_valid), .busy(busy), .done(done), .aborted(aborted),
    .perf_cycles(perf_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp, n_err, cyc;
  string tname;
  logic [63:0] rd_q[$], wr_q[$], dsm_q[$];
  int rd_owed, wr_owed, dsm_owed, outst, avail, busy_cnt;
  bit rd_auto, wr_auto, rnd_af, rnd_rsp, done_seen;
  int last_data_rsp_cyc, dsm_rsp_cyc, dsm_cyc, done_cyc;
  logic [63:0] j_src, j_dst, j_dsm;
  logic [31:0] j_size;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL [%s] %s: got %0h, expected %0h (cycle %0d)", tname, tag, got, exp, cyc);
    end
  endtask

  // One clock: observe this cycle's registered outputs, then drive this cycle's inputs.
  task automatic cycle();
    logic pc0, pc1;
    bit new_rd, new_wr, new_dsm;
    pc0 = c0_almfull; pc1 = c1_almfull;
    @(posedge clk); #1;
    cyc++;
    ctl_start = 0; ctl_stop = 0; rd_rsp_valid = 0; wr_rsp_valid = 0;
    new_rd = 0; new_wr = 0; new_dsm = 0;
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1 && !done_seen) begin done_seen = 1; done_cyc = cyc; end
    if (rd_req_valid === 1'b1) begin
      chk("rd_under_almfull", {63'd0, pc0}, 64'd0);
      rd_q.push_back(64'(rd_req_addr));
      outst++;
      chk("outstanding_limit", {63'd0, outst <= MAXO}, 64'd1);
      new_rd = 1;
    end
    if (wr_req_valid === 1'b1) begin
      chk("wr_under_almfull", {63'd0, pc1}, 64'd0);
      if (wr_req_is_dsm) begin dsm_q.push_back(64'(wr_req_addr)); dsm_cyc = cyc; new_dsm = 1; end
      else begin wr_q.push_back(64'(wr_req_addr)); new_wr = 1; end
    end
    if (out_line_ready === 1'b1 || new_wr) chk("line_ready", {63'd0, out_line_ready}, {63'd0, new_wr});
    if (out_line_ready === 1'b1 && avail > 0) avail--;
    if (rnd_af) begin
      c0_almfull = ($urandom_range(3) == 0);
      c1_almfull = ($urandom_range(3) == 0);
    end
    if (rd_auto && rd_owed > 0 && (!rnd_rsp || $urandom_range(1) == 1)) begin
      rd_rsp_valid = 1; rd_owed--; outst--; avail++;
    end
    if (wr_auto && (wr_owed + dsm_owed) > 0 && (!rnd_rsp || $urandom_range(1) == 1)) begin
      wr_rsp_valid = 1;
      if (wr_owed > 0) begin wr_owed--; if (wr_owed == 0) last_data_rsp_cyc = cyc; end
      else begin dsm_owed--; dsm_rsp_cyc = cyc; end
    end
    rd_owed += int'(new_rd); wr_owed += int'(new_wr); dsm_owed += int'(new_dsm);
    out_line_valid = (avail > 0);
  endtask

  task automatic start_job(input logic [63:0] s, input logic [63:0] d, input logic [63:0] m,
                           input logic [31:0] sz);
    j_src = s; j_dst = d; j_dsm = m; j_size = sz;
    rd_q.delete(); wr_q.delete(); dsm_q.delete();
    rd_owed = 0; wr_owed = 0; dsm_owed = 0; outst = 0; avail = 0; busy_cnt = 0;
    done_seen = 0; out_line_valid = 0; rd_rsp_valid = 0; wr_rsp_valid = 0;
    src_addr = s; dst_addr = d; dsm_addr = m; size = sz; ctl_start = 1;
    cycle();
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    chk("done_cleared", {63'd0, done}, 64'd0);
    chk("aborted_cleared", {63'd0, aborted}, 64'd0);
  endtask

  task automatic check_job();
    longint unsigned n;
    n = longint'(j_size / 64) + ((j_size % 64) != 0 ? 1 : 0);
    chk("done", {63'd0, done}, 64'd1);
    chk("aborted", {63'd0, aborted}, 64'd0);
    chk("busy_end", {63'd0, busy}, 64'd0);
    chk("n_reads", rd_q.size(), n);
    chk("n_writes", wr_q.size(), n);
    for (int i = 0; i < rd_q.size() && i < n; i++)
      chk("rd_addr", rd_q[i], ((j_src >> 6) + i) & LMASK);
    for (int i = 0; i < wr_q.size() && i < n; i++)
      chk("wr_addr", wr_q[i], ((j_dst >> 6) + i) & LMASK);
    chk("n_dsm", dsm_q.size(), 1);
    if (dsm_q.size() > 0) chk("dsm_addr", dsm_q[0], (j_dsm >> 6) & LMASK);
`ifdef SOBEL_DMA_PERF_EN
    chk("perf_cycles", 64'(perf_cycles), busy_cnt);
`else
    chk("perf_tied0", 64'(perf_cycles), 64'd0);
`endif
  endtask

  task automatic finish_job(input int budget);
    for (int i = 0; i < budget && done !== 1'b1; i++) cycle();
    repeat (3) cycle();
    check_job();
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; tname = "reset";
    reset_n = 0; ctl_start = 0; ctl_stop = 0; src_addr = 0; dst_addr = 0; dsm_addr = 0;
    size = 0; c0_almfull = 0; c1_almfull = 0; rd_rsp_valid = 0; wr_rsp_valid = 0;
    out_line_valid = 0; rd_auto = 1; wr_auto = 1; rnd_af = 0; rnd_rsp = 0;
    repeat (3) cycle();
    reset_n = 1;
    cycle();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_rd_valid", {63'd0, rd_req_valid}, 64'd0);
    chk("rst_wr_valid", {63'd0, wr_req_valid}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_aborted", {63'd0, aborted}, 64'd0);
    chk("rst_perf", 64'(perf_cycles), 64'd0);

    tname = "basic256";
    start_job(64'h1000, 64'h2000, 64'h3000, 256);
    finish_job(200);
    chk("dsm_latency", dsm_cyc - last_data_rsp_cyc, 1);
    chk("done_latency", done_cyc - dsm_rsp_cyc, 1);

    tname = "size100"; start_job(64'h4_0040, 64'h8_0000, 64'hC_0000, 100); finish_job(200);
    tname = "size0";   start_job(64'h1000, 64'h2000, 64'h5000, 0);        finish_job(50);
    tname = "wrap";    start_job(64'hFFFF_FFFF_FFC0, 64'h7000, 64'h9000, 128); finish_job(200);

    tname = "outstanding";
    rd_auto = 0;
    start_job(64'h10_0000, 64'h20_0000, 64'h30_0000, 1024);
    repeat (20) cycle();
    chk("stall_at_limit", rd_q.size(), MAXO);
    for (int k = 0; k < 2; k++) begin
      rd_rsp_valid = 1; rd_owed--; outst--; avail++; out_line_valid = 1;
      repeat (6) cycle();
      chk("one_released", rd_q.size(), MAXO + 1 + k);
    end
    rd_auto = 1;
    finish_job(400);

    tname = "almfull";
    start_job(64'h40_0000, 64'h50_0000, 64'h60_0000, 1024);
    for (int i = 0; i < 50 && rd_q.size() < 3; i++) cycle();
    begin
      int n0;
      n0 = rd_q.size(); c0_almfull = 1;
      repeat (10) cycle();
      chk("c0_hold", rd_q.size(), n0);
      c0_almfull = 0; cycle();
      chk("c0_resume", {63'd0, rd_req_valid}, 64'd1);
      n0 = wr_q.size(); c1_almfull = 1;
      repeat (10) cycle();
      chk("c1_hold", wr_q.size(), n0);
      c1_almfull = 0; cycle();
      chk("c1_resume", {63'd0, wr_req_valid & ~wr_req_is_dsm}, 64'd1);
    end
    finish_job(400);

    tname = "dsm_almfull";
    start_job(64'h1_0000, 64'h2_0000, 64'h3_0000, 64);
    for (int i = 0; i < 50 && wr_q.size() < 1; i++) cycle();
    c1_almfull = 1;
    repeat (10) cycle();
    chk("dsm_hold", dsm_q.size(), 0);
    c1_almfull = 0; cycle();
    chk("dsm_resume", {63'd0, wr_req_valid & wr_req_is_dsm}, 64'd1);
    finish_job(50);

    tname = "stop";
    rd_auto = 0;
    start_job(64'h7_0000, 64'h8_0000, 64'h9_0000, 512);
    for (int i = 0; i < 50 && rd_q.size() < 3; i++) cycle();
    ctl_stop = 1; cycle();
    repeat (6) cycle();
    chk("stop_reads", rd_q.size(), 3);
    chk("stop_draining", {63'd0, busy}, 64'd1);
    rd_auto = 1;
    for (int i = 0; i < 100 && aborted !== 1'b1; i++) cycle();
    repeat (3) cycle();
    chk("stop_aborted", {63'd0, aborted}, 64'd1);
    chk("stop_done", {63'd0, done}, 64'd0);
    chk("stop_busy", {63'd0, busy}, 64'd0);
    chk("stop_reads_final", rd_q.size(), 3);
    chk("stop_writes", wr_q.size(), 0);
    chk("stop_no_dsm", dsm_q.size(), 0);
    tname = "after_stop";
    start_job(64'h7_0000, 64'h8_0000, 64'h9_0000, 512);
    finish_job(300);

    tname = "random";
    rnd_af = 1; rnd_rsp = 1;
    for (int j = 0; j < 8; j++) begin
      start_job({$urandom, $urandom} & ~64'h3F, {$urandom, $urandom} & ~64'h3F,
                {$urandom, $urandom} & ~64'h3F, 32'($urandom_range(0, 1500)));
      finish_job(4000);
    end
    rnd_af = 0; rnd_rsp = 0; c0_almfull = 0; c1_almfull = 0;

    tname = "midrun_reset";
    rd_auto = 0;
    start_job(64'hA_0000, 64'hB_0000, 64'hC_0000, 1024);
    for (int i = 0; i < 50 && rd_q.size() < MAXO; i++) cycle();
    reset_n = 0; cycle();
    chk("mr_busy", {63'd0, busy}, 64'd0);
    chk("mr_rd_valid", {63'd0, rd_req_valid}, 64'd0);
    chk("mr_wr_valid", {63'd0, wr_req_valid}, 64'd0);
    chk("mr_is_dsm", {63'd0, wr_req_is_dsm}, 64'd0);
    chk("mr_ready", {63'd0, out_line_ready}, 64'd0);
    chk("mr_done", {63'd0, done}, 64'd0);
    chk("mr_aborted", {63'd0, aborted}, 64'd0);
    chk("mr_perf", 64'(perf_cycles), 64'd0);
    reset_n = 1;
    rd_q.delete(); wr_q.delete(); dsm_q.delete();
    rd_owed = 0; wr_owed = 0; dsm_owed = 0; outst = 0; avail = 0; out_line_valid = 0;
    for (int i = 0; i < 5; i++) begin rd_rsp_valid = 1; wr_rsp_valid = 1; cycle(); end
    repeat (5) cycle();
    chk("late_rsp_no_rd", rd_q.size(), 0);
    chk("late_rsp_no_wr", wr_q.size() + dsm_q.size(), 0);
    chk("late_rsp_idle", {63'd0, busy}, 64'd0);
    rd_auto = 1;
    tname = "after_reset";
    start_job(64'h1000, 64'h2000, 64'h3000, 320);
    finish_job(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
